// File: rtl/l1mtx_out_arbiter.sv
// Round-robin address-phase arbiter for one bus-matrix output port.
// Holds the grant across bursts and locked sequences and tracks the data-phase owner.
module l1mtx_out_arbiter #(
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned PORT_W = 2
) (
   input  logic                HCLK,
   input  logic                HRESET,
   input  logic [NUM_IN-1:0]   req_sel,
   input  logic [2*NUM_IN-1:0] req_trans,
   input  logic [NUM_IN-1:0]   req_mastlock,
   input  logic                HREADYM,
   output logic [PORT_W-1:0]   addr_in_port,
   output logic                no_port,
   output logic [NUM_IN-1:0]   active,
   output logic [PORT_W-1:0]   data_in_port,
   output logic                data_valid
);

   localparam logic [1:0] ST_NOGRANT = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        w_state_d;
   logic [PORT_W-1:0] r_addr_port;
   logic [PORT_W-1:0] w_addr_port_d;
   logic [PORT_W-1:0] r_last;
   logic [PORT_W-1:0] w_last_d;
   logic [PORT_W-1:0] r_data_port;
   logic              r_data_valid;

   logic              w_granted;
   logic              w_own_sel;
   logic              w_own_lock;
   logic [1:0]        w_own_trans;
   logic              w_hold;
   logic              w_found;
   logic [PORT_W-1:0] w_winner;
   logic              w_win_lock;
   int unsigned       w_best_dist;
   int unsigned       w_dist;

   assign w_granted = (r_state != ST_NOGRANT);

   // Request signals of the current address-phase owner.
   always_comb begin
      w_own_sel   = 1'b0;
      w_own_lock  = 1'b0;
      w_own_trans = 2'b00;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (r_addr_port == PORT_W'(i)) begin
            w_own_sel   = req_sel[i];
            w_own_lock  = req_mastlock[i];
            w_own_trans = req_trans[2*i +: 2];
         end
      end
   end

   // BUSY and SEQ both have HTRANS[0] set.
   assign w_hold = w_granted & w_own_sel & (w_own_trans[0] | w_own_lock);

   // Winner is the requester with the smallest distance past the last winner.
   always_comb begin
      w_found     = 1'b0;
      w_winner    = r_last;
      w_win_lock  = 1'b0;
      w_best_dist = NUM_IN;
      w_dist      = 0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         w_dist = (i + NUM_IN - 1 - 32'(r_last)) % NUM_IN;
         if (req_sel[i] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_winner    = PORT_W'(i);
            w_win_lock  = req_mastlock[i];
            w_found     = 1'b1;
         end
      end
   end

   always_comb begin
      w_addr_port_d = r_addr_port;
      w_last_d      = r_last;
      w_state_d     = r_state;
      if (w_hold) begin
         w_state_d = w_own_lock ? ST_LOCKED : ST_GRANT;
      end else if (w_found) begin
         w_addr_port_d = w_winner;
         w_last_d      = w_winner;
         w_state_d     = w_win_lock ? ST_LOCKED : ST_GRANT;
      end else begin
         w_state_d = ST_NOGRANT;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state      <= ST_NOGRANT;
         r_addr_port  <= '0;
         r_last       <= PORT_W'(NUM_IN - 1);
         r_data_port  <= '0;
         r_data_valid <= 1'b0;
      end else if (HREADYM) begin
         r_state      <= w_state_d;
         r_addr_port  <= w_addr_port_d;
         r_last       <= w_last_d;
         r_data_port  <= r_addr_port;
         r_data_valid <= w_granted & w_own_trans[1];
      end
   end

   assign addr_in_port = r_addr_port;
   assign no_port      = ~w_granted;
   assign data_in_port = r_data_port;
   assign data_valid   = r_data_valid;

   always_comb begin
      active = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         active[i] = w_granted & (r_addr_port == PORT_W'(i));
      end
   end

endmodule
